contador_mod10: RTL and testbench
=================================

Name: contador_mod10

Overview:
- Single-digit BCD down-counter (modulus 10), the building block of the multi-digit timer/counter in the contador hierarchy.
- Supports synchronous parallel load and count enable.
- Provides a terminal-count output for cascading to the next, more significant digit, and a zero flag.

Parameters:
- MODULUS, 10, count range is 0..MODULUS-1; wraps from 0 to MODULUS-1.
- WIDTH, 4, width of data and count; must satisfy 2^WIDTH >= MODULUS.

Ports:
- clk  input  1  system clock; all state changes on the rising edge except reset.
- clrn  input  1  reset; one clock, reset is asynchronous and active-low.
- data  input  WIDTH  parallel load value.
- loadn  input  1  active-low synchronous load.
- en  input  1  active-high count enable.
- count  output  WIDTH  current digit value, registered.
- tc  output  1  terminal count / borrow to the next digit, combinational.
- zero  output  1  high when count == 0, combinational from count.

Behaviour:
- Reset: clrn low forces count = 0 immediately, independent of clk.
  - While clrn is low, count stays 0, so zero = 1 and tc = en.
  - Release of clrn takes effect at the next rising edge.
- Per rising edge with clrn high, priority is load > count > hold.
  - loadn = 0: count <= data, with the out-of-range rule below. en is ignored.
  - loadn = 1, en = 1: count <= count - 1; if count == 0 then count <= MODULUS-1 (wrap 0 -> 9).
  - loadn = 1, en = 0: count holds.
- Latency:
  - Load visible on count one edge after loadn is sampled low.
  - Each decrement takes exactly one enabled edge.
- tc = en AND (count == 0) AND loadn.
  - Asserted during the cycle in which the next enabled edge wraps 0 -> 9.
  - Intended to drive the en of the next digit.
  - Deasserted while loading.
- zero = (count == 0), regardless of en or loadn.
- Out-of-range load (data > MODULUS-1, e.g. 10..15): behaviour is set by the optional feature; the counter never holds a value above MODULUS-1 after the next enabled edge.
- No glitches on count; tc and zero are decoded from registered count plus inputs.
- Reset mid-count: count goes to 0 immediately. The first enabled edge after release gives 9.

Optional Feature:
- Macro CONTADOR_MOD10_SAT_LOAD_EN.
- Defined: a load with data > MODULUS-1 loads MODULUS-1 (9), so count is always in 0..9.
- Not defined: data is loaded verbatim, e.g. 12.
  - An enabled edge from any value >= MODULUS loads MODULUS-1, so 12 -> 9 -> 8.
  - zero = 0 and tc = 0 while out of range.

Test Plan:
- Reset: clrn = 0 with count at 5, asynchronously and mid-cycle -> count = 0, zero = 1 before any clk edge; tc follows en.
- Load: data = 6, loadn = 0 across one rising edge, en = 0 -> count = 6, zero = 0, tc = 0; holds at 6 for further edges with loadn = 1, en = 0.
- Count/wrap: after loading 6, set en = 1 for 13 rising edges -> sequence 5,4,3,2,1,0,9,8,7,6,5,4,3. tc = 1 only while count = 0; zero = 1 only at 0.
- Priority: count = 3, loadn = 0, en = 1, data = 8 -> next count = 8, not 2; tc = 0 while loadn = 0 even if count = 0.
- Enable gating: count = 0, en = 0 for 3 edges -> count stays 0, zero = 1, tc = 0; en = 1 -> tc = 1 and the next edge gives 9.
- Out-of-range load: data = 12 with the macro defined -> count = 9. Without the macro -> count = 12, then 9 after one enabled edge.

Source files
------------

// File: rtl/contador_mod10.sv
// contador_mod10: single-digit BCD down-counter (modulus MODULUS, default 10).
//
// Ports:
//   clk    in           rising-edge clock
//   clrn   in           asynchronous active-low reset, forces count to 0
//   data   in  [WIDTH]  parallel load value
//   loadn  in           active-low synchronous load (beats en)
//   en     in           active-high count enable (decrement, 0 wraps to MODULUS-1)
//   count  out [WIDTH]  registered digit value
//   tc     out          borrow to the next digit: en & (count == 0) & loadn
//   zero   out          count == 0
//
// Optional feature macro: CONTADOR_MOD10_SAT_LOAD_EN
//   defined   : loads above MODULUS-1 are clamped to MODULUS-1
//   undefined : loads are taken verbatim; the next enabled edge from an
//               out-of-range value goes to MODULUS-1
module contador_mod10 #(
  parameter int unsigned MODULUS = 10,
  parameter int unsigned WIDTH   = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] data,
  input  logic             loadn,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] load_val;

`ifdef CONTADOR_MOD10_SAT_LOAD_EN
  assign load_val = (data > MaxVal) ? MaxVal : data;
`else
  assign load_val = data;
`endif

  always_comb begin
    count_d = count_q;
    if (!loadn) begin
      count_d = load_val;
    end else if (en) begin
      // Wrap at zero; an out-of-range value also recovers to the top digit.
      if (count_q == '0 || count_q > MaxVal) begin
        count_d = MaxVal;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);
  assign tc    = en & zero & loadn;

endmodule

// File: tb/tb_contador_mod10.sv
module tb_contador_mod10;

  localparam int MOD = 10;

  logic       clk = 1'b0;
  logic       clrn;
  logic [3:0] data;
  logic       loadn;
  logic       en;
  logic [3:0] count;
  logic       tc;
  logic       zero;

  int n_cmp = 0;
  int n_err = 0;

  contador_mod10 #(
    .MODULUS(10),
    .WIDTH  (4)
  ) dut (
    .clk  (clk),
    .clrn (clrn),
    .data (data),
    .loadn(loadn),
    .en   (en),
    .count(count),
    .tc   (tc),
    .zero (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       loadn;
    logic       en;
    logic [3:0] data;
    int         exp_count;
    logic       exp_tc;
    logic       exp_zero;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int c, input int t, input int z);
    check({name, ".count"}, int'(count), c);
    check({name, ".tc"}, int'(tc), t);
    check({name, ".zero"}, int'(zero), z);
  endtask

  // Behavioural reference: value of the digit after one rising edge.
  function automatic int model_next(input int c, input bit ld_n, input bit e, input int d);
    if (!ld_n) begin
`ifdef CONTADOR_MOD10_SAT_LOAD_EN
      return (d > MOD - 1) ? MOD - 1 : d;
`else
      return d;
`endif
    end
    if (!e) return c;
    if (c >= MOD) return MOD - 1;
    return (c + MOD - 1) % MOD;
  endfunction

  task automatic add(input logic ln, input logic e, input int d, input int c, input logic t,
                     input logic z);
    vec_t v;
    v.loadn = ln; v.en = e; v.data = 4'(d);
    v.exp_count = c; v.exp_tc = t; v.exp_zero = z;
    vecs.push_back(v);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq[13] = '{5, 4, 3, 2, 1, 0, 9, 8, 7, 6, 5, 4, 3};
    int m;

    // Load 6, hold, then count 13 edges through the wrap.
    add(1'b0, 1'b0, 6, 6, 1'b0, 1'b0);
    add(1'b1, 1'b0, 0, 6, 1'b0, 1'b0);
    add(1'b1, 1'b0, 0, 6, 1'b0, 1'b0);
    foreach (seq[i]) add(1'b1, 1'b1, 0, seq[i], seq[i] == 0, seq[i] == 0);
    // Priority: load beats count; tc suppressed while loading.
    add(1'b0, 1'b0, 3, 3, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8, 8, 1'b0, 1'b0);
    add(1'b0, 1'b1, 0, 0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 0, 0, 1'b0, 1'b1);
    // Enable gating at zero.
    add(1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 0, 0, 1'b0, 1'b1);

    clrn = 1'b0; loadn = 1'b1; en = 1'b0; data = '0;
    #12;
    check_all("reset", 0, 0, 1);
    en = 1'b1;
    #1;
    check("reset.tc_follows_en", int'(tc), 1);
    en = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    tick();
    check("after_release.count", int'(count), 0);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      loadn = vecs[i].loadn; en = vecs[i].en; data = vecs[i].data;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].exp_count, int'(vecs[i].exp_tc),
                int'(vecs[i].exp_zero));
    end

    // Enable at zero: tc rises before the edge, then the edge gives 9.
    loadn = 1'b1; en = 1'b1;
    #1;
    check("gate.tc_before_edge", int'(tc), 1);
    tick();
    check_all("gate.wrap", 9, 0, 0);

    // Asynchronous reset mid-cycle with count at 5.
    loadn = 1'b0; en = 1'b0; data = 4'd5;
    tick();
    loadn = 1'b1;
    check("async.preload", int'(count), 5);
    #3;
    clrn = 1'b0;
    #1;
    check_all("async.mid", 0, 0, 1);
    @(negedge clk);
    clrn = 1'b1;
    en = 1'b1;
    tick();
    check("async.first_edge", int'(count), 9);

    // Out-of-range load.
    loadn = 1'b0; en = 1'b0; data = 4'd12;
    tick();
    loadn = 1'b1; en = 1'b1;
    #1;
`ifdef CONTADOR_MOD10_SAT_LOAD_EN
    check_all("oor.load", 9, 0, 0);
`else
    check_all("oor.load", 12, 0, 0);
`endif
    tick();
`ifdef CONTADOR_MOD10_SAT_LOAD_EN
    check("oor.edge1", int'(count), 8);
`else
    check("oor.edge1", int'(count), 9);
`endif

    // Randomized run against the reference model.
    m = int'(count);
    for (int i = 0; i < 400; i++) begin
      clrn  = ($urandom_range(0, 19) != 0);
      loadn = ($urandom_range(0, 4) != 0);
      en    = $urandom_range(0, 1);
      data  = 4'($urandom_range(0, 15));
      #1;
      if (!clrn) m = 0;
      check_all($sformatf("rnd%0d", i), m, (en && loadn && m == 0) ? 1 : 0, (m == 0) ? 1 : 0);
      @(posedge clk);
      if (clrn) m = model_next(m, loadn, en, int'(data));
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
